// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, lane types, clog2 helper.
package cpu_pkg;

   localparam int unsigned IW_DEFAULT = 16;
   localparam int unsigned AW_DEFAULT = 16;

   typedef logic [IW_DEFAULT-1:0] inst_t;
   typedef logic [AW_DEFAULT-1:0] pc_t;

   // Ceiling log2, floored at 1 so it can always size a vector.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return (result == 0) ? 1 : result;
   endfunction

endpackage

// File: rtl/fetch_queue_lane_select.sv
// Maps a base pointer to LANES consecutive slot indices, wrapping modulo DEPTH.
module fetch_queue_lane_select
   import cpu_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic [clog2(DEPTH)-1:0]       base,
   output logic [LANES*clog2(DEPTH)-1:0] idx
);

   localparam int unsigned PW = clog2(DEPTH);

   // DEPTH is a power of two, so PW-bit addition wraps for free.
   always_comb begin
      idx = '0;
      for (int i = 0; i < LANES; i++) begin
         idx[i*PW +: PW] = base + PW'(i);
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-lane instruction fetch queue between fetch and decode, with flush and
// sticky protocol-error flag.
module inst_fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IW    = IW_DEFAULT,
   parameter int unsigned AW    = AW_DEFAULT
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [clog2(LANES+1)-1:0]  in_count,
   input  logic [LANES*IW-1:0]        in_inst,
   input  logic [LANES*AW-1:0]        in_pc,
   output logic                       in_ready,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*IW-1:0]        out_inst,
   output logic [LANES*AW-1:0]        out_pc,
   input  logic [clog2(LANES+1)-1:0]  out_take,
   input  logic                       flush,
   output logic [clog2(DEPTH+1)-1:0]  count,
   output logic                       err
);

   localparam int unsigned CW = clog2(LANES+1);
   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned NW = clog2(DEPTH+1);
   localparam int unsigned EW = IW + AW;

   logic [EW-1:0]       mem_q [DEPTH];
   logic [PW-1:0]       head_q, head_d;
   logic [PW-1:0]       tail_q, tail_d;
   logic [NW-1:0]       count_q, count_d;
   logic                err_q, err_d;

   logic [CW-1:0]       in_n;
   logic [CW-1:0]       push_n;
   logic [NW-1:0]       pop_n;
   logic [LANES*PW-1:0] rd_idx;
   logic [LANES*PW-1:0] wr_idx;

   fetch_queue_lane_select #(
      .LANES (LANES),
      .DEPTH (DEPTH)
   ) u_rd_select (
      .base (head_q),
      .idx  (rd_idx)
   );

   fetch_queue_lane_select #(
      .LANES (LANES),
      .DEPTH (DEPTH)
   ) u_wr_select (
      .base (tail_q),
      .idx  (wr_idx)
   );

   // Ready depends on registered occupancy only, never on same-cycle take.
   assign in_ready = (NW'(DEPTH) - count_q) >= NW'(LANES);

   // Next-state: clamp, push/pop amounts, flush priority and error detection.
   always_comb begin
      in_n   = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;
      push_n = (in_ready && !flush) ? in_n : '0;
      pop_n  = '0;
      if (!flush) begin
         pop_n = (NW'(out_take) < count_q) ? NW'(out_take) : count_q;
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(pop_n);
         tail_d  = tail_q + PW'(push_n);
         count_d = count_q - pop_n + NW'(push_n);
      end
      err_d = err_q | (!flush && ((NW'(out_take) > count_q) || (in_count > CW'(LANES))));
   end

   // Pointer, occupancy and error state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Entry storage; contents survive reset but are masked by count.
   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++) begin
         if (CW'(i) < push_n) begin
            mem_q[wr_idx[i*PW +: PW]] <= {in_pc[i*AW +: AW], in_inst[i*IW +: IW]};
         end
      end
   end

   // Oldest entries to output lanes; lanes past occupancy read as zero.
   always_comb begin
      out_valid = '0;
      out_inst  = '0;
      out_pc    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (count_q > NW'(i)) begin
            out_valid[i]        = 1'b1;
            out_inst[i*IW +: IW] = mem_q[rd_idx[i*PW +: PW]][IW-1:0];
            out_pc[i*AW +: AW]   = mem_q[rd_idx[i*PW +: PW]][EW-1:IW];
         end
      end
   end

   assign count = count_q;
   assign err   = err_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (LANES=2, DEPTH=8, IW=AW=16).
module tb_inst_fetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  in_count;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [1:0]  out_take;
   logic        flush;
   logic [3:0]  count;
   logic        err;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO of {pc, inst} entries plus sticky error.
   logic [31:0] mq[$];
   bit          merr;

   inst_fetch_queue #(
      .LANES (2),
      .DEPTH (8),
      .IW    (16),
      .AW    (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_count  (in_count),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_take  (out_take),
      .flush     (flush),
      .count     (count),
      .err       (err)
   );

   always #5 clock = ~clock;

   task automatic model_step(input int cnt, input int take, input bit fl);
      int sz;
      int cl;
      int pn;
      int tn;
      bit rdy;
      sz  = mq.size();
      rdy = (8 - sz) >= 2;
      cl  = (cnt > 2) ? 2 : cnt;
      pn  = (rdy && !fl) ? cl : 0;
      tn  = fl ? 0 : ((take < sz) ? take : sz);
      if (!fl && (take > sz || cnt > 2)) merr = 1'b1;
      if (fl) begin
         mq.delete();
      end else begin
         repeat (tn) void'(mq.pop_front());
         for (int k = 0; k < pn; k++) mq.push_back({in_pc[k*16 +: 16], in_inst[k*16 +: 16]});
      end
   endtask

   function automatic void exp_out(output logic [1:0] v, output logic [31:0] ei,
                                   output logic [31:0] ep);
      v  = '0;
      ei = '0;
      ep = '0;
      for (int k = 0; k < 2; k++) begin
         if (k < mq.size()) begin
            v[k]           = 1'b1;
            ei[k*16 +: 16] = mq[k][15:0];
            ep[k*16 +: 16] = mq[k][31:16];
         end
      end
   endfunction

   task automatic drive(input int cnt, input int take, input bit fl,
                        input logic [31:0] inst, input logic [31:0] pc);
      in_count = 2'(cnt);
      out_take = 2'(take);
      flush    = fl;
      in_inst  = inst;
      in_pc    = pc;
      model_step(cnt, take, fl);
      @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      in_count = '0;
      out_take = '0;
      flush    = 1'b0;
      in_inst  = '0;
      in_pc    = '0;
      reset    = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      mq.delete();
      merr = 1'b0;
   endtask

   task automatic test_reset();
      in_count = 2'd2;
      out_take = '0;
      flush    = 1'b0;
      in_inst  = 32'h1234_5678;
      in_pc    = 32'h0002_0000;
      reset    = 1'b1;
      #3;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
         bad++; $display("FAIL reset_lanes got pc=%h inst=%h exp=0", out_pc, out_inst);
      end
      reset_dut();
      drive(0, 0, 0, 32'h0, 32'h0);
      total++; if (count !== 4'd0 || out_valid !== 2'b00) begin
         bad++; $display("FAIL idle got count=%0d valid=%b exp=0/00", count, out_valid);
      end
   endtask

   task automatic test_push_seq();
      reset_dut();
      drive(2, 0, 0, 32'hBBBB_AAAA, 32'h0002_0000);
      total++; if (out_valid !== 2'b11) begin bad++; $display("FAIL push_valid got=%b exp=11", out_valid); end
      total++; if (out_pc !== 32'h0002_0000) begin bad++; $display("FAIL push_pc got=%h exp=00020000", out_pc); end
      total++; if (out_inst !== 32'hBBBB_AAAA) begin bad++; $display("FAIL push_inst got=%h exp=bbbbaaaa", out_inst); end
      total++; if (count !== 4'd2) begin bad++; $display("FAIL push_count got=%0d exp=2", count); end
      for (int b = 1; b < 4; b++) drive(2, 0, 0, 32'h5555_5555, {16'(4*b+2), 16'(4*b)});
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
      drive(2, 0, 0, 32'h6666_6666, 32'h0012_0010);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL held_count got=%0d exp=8", count); end
      drive(2, 2, 0, 32'h6666_6666, 32'h0012_0010);
      total++; if (count !== 4'd6) begin bad++; $display("FAIL take_full_count got=%0d exp=6", count); end
      total++; if (out_pc !== 32'h0006_0004) begin bad++; $display("FAIL take_full_pc got=%h exp=00060004", out_pc); end
      drive(2, 0, 0, 32'h6666_6666, 32'h0012_0010);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL held_accept got=%0d exp=8", count); end
      for (int b = 0; b < 3; b++) drive(0, 2, 0, 32'h0, 32'h0);
      total++; if (count !== 4'd2 || out_pc !== 32'h0012_0010) begin
         bad++; $display("FAIL held_drain got count=%0d pc=%h exp=2/00120010", count, out_pc);
      end
   endtask

   task automatic test_simul();
      reset_dut();
      drive(2, 0, 0, 32'h0, 32'h0002_0000);
      drive(1, 0, 0, 32'h0, 32'hFFFF_0004);
      total++; if (count !== 4'd3) begin bad++; $display("FAIL simul_pre got=%0d exp=3", count); end
      drive(2, 1, 0, 32'h0, 32'h0008_0006);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL simul_count got=%0d exp=4", count); end
      total++; if (out_pc !== 32'h0004_0002) begin bad++; $display("FAIL simul_pc got=%h exp=00040002", out_pc); end
   endtask

   task automatic test_wrap();
      reset_dut();
      for (int b = 0; b < 4; b++) drive(2, 0, 0, 32'h0, {16'(4*b+2), 16'(4*b)});
      for (int b = 0; b < 3; b++) drive(0, 2, 0, 32'h0, 32'h0);
      total++; if (count !== 4'd2 || out_pc !== 32'h000E_000C) begin
         bad++; $display("FAIL wrap_pre got count=%0d pc=%h exp=2/000e000c", count, out_pc);
      end
      drive(2, 2, 0, 32'hC1C1_C0C0, 32'h00A2_00A0);
      total++; if (count !== 4'd2 || out_valid !== 2'b11) begin
         bad++; $display("FAIL wrap_count got count=%0d valid=%b exp=2/11", count, out_valid);
      end
      total++; if (out_pc !== 32'h00A2_00A0 || out_inst !== 32'hC1C1_C0C0) begin
         bad++; $display("FAIL wrap_lanes got pc=%h inst=%h exp=00a200a0/c1c1c0c0", out_pc, out_inst);
      end
   endtask

   task automatic test_flush();
      reset_dut();
      drive(2, 0, 0, 32'h0, 32'h0002_0000);
      drive(2, 0, 0, 32'h0, 32'h0006_0004);
      drive(1, 0, 0, 32'h0, 32'h0000_0008);
      total++; if (count !== 4'd5 || in_ready !== 1'b1) begin
         bad++; $display("FAIL flush_pre got count=%0d ready=%b exp=5/1", count, in_ready);
      end
      drive(2, 2, 1, 32'h7777_7777, 32'h0042_0040);
      total++; if (count !== 4'd0 || out_valid !== 2'b00 || out_pc !== 32'h0) begin
         bad++; $display("FAIL flush got count=%0d valid=%b pc=%h exp=0/00/0", count, out_valid, out_pc);
      end
      drive(0, 0, 0, 32'h0, 32'h0);
      total++; if (count !== 4'd0 || err !== 1'b0) begin
         bad++; $display("FAIL flush_after got count=%0d err=%b exp=0/0", count, err);
      end
   endtask

   task automatic test_error();
      reset_dut();
      drive(1, 0, 0, 32'h0, 32'h0000_0010);
      drive(0, 2, 0, 32'h0, 32'h0);
      total++; if (count !== 4'd0 || err !== 1'b1) begin
         bad++; $display("FAIL err_set got count=%0d err=%b exp=0/1", count, err);
      end
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 32'h0, 32'h0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_async_clear got=%b exp=0", err); end
      reset = 1'b0;
      mq.delete();
      merr = 1'b0;
      drive(3, 0, 0, 32'h0, 32'h0022_0020);
      total++; if (count !== 4'd2 || err !== 1'b1) begin
         bad++; $display("FAIL err_clamp got count=%0d err=%b exp=2/1", count, err);
      end
   endtask

   task automatic test_random();
      logic [1:0]  ev;
      logic [31:0] ei;
      logic [31:0] ep;
      int          cnt;
      int          take;
      bit          fl;
      reset_dut();
      for (int c = 0; c < 500; c++) begin
         if (c == 250) reset_dut();
         cnt  = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
         take = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
         fl   = ($urandom_range(0, 19) == 0);
         drive(cnt, take, fl, $urandom, $urandom);
         exp_out(ev, ei, ep);
         total++; if (count !== 4'(mq.size())) begin
            bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, mq.size());
         end
         total++; if (in_ready !== ((8 - mq.size()) >= 2)) begin
            bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, (8 - mq.size()) >= 2);
         end
         total++; if (out_valid !== ev) begin
            bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, ev);
         end
         total++; if (out_inst !== ei) begin
            bad++; $display("FAIL rand_inst cyc=%0d got=%h exp=%h", c, out_inst, ei);
         end
         total++; if (out_pc !== ep) begin
            bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", c, out_pc, ep);
         end
         total++; if (err !== merr) begin
            bad++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err, merr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_seq();
      test_simul();
      test_wrap();
      test_flush();
      test_error();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Parameter LANES, 2, instructions per bundle on both the push and pop sides; legal range 1..4.
REQ-003 Parameter DEPTH, 8, queue entries; power of two, at least 2*LANES.
REQ-004 Parameter IW, 16, instruction width in bits.
REQ-005 Parameter AW, 16, PC width in bits.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_count  input  clog2(LANES+1)  number of valid pushed lanes; packed from lane 0; values above LANES are clamped to LANES.
REQ-009 in_inst  input  LANES*IW  pushed instructions; lane i occupies bits [i*IW +: IW].
REQ-010 in_pc  input  LANES*AW  PC of each pushed lane.
REQ-011 in_ready  output  1  high when at least LANES entries are free.
REQ-012 out_valid  output  LANES  thermometer code; bit i is high when occupancy > i.
REQ-013 out_inst  output  LANES*IW  the oldest LANES entries in order; lane 0 is the oldest.
REQ-014 out_pc  output  LANES*AW  PC of each output lane.
REQ-015 out_take  input  clog2(LANES+1)  number of entries the decoder consumes this cycle.
REQ-016 flush  input  1  discards all queue contents (branch redirect).
REQ-017 count  output  clog2(DEPTH+1)  current occupancy.
REQ-018 err  output  1  sticky flag for a protocol violation.

Function
REQ-019 Push:
- push_n = clamped in_count when in_ready is high and flush is low; otherwise push_n = 0.
- Lanes 0..push_n-1 are written at tail, tail+1, ... modulo DEPTH.
REQ-020 Pop:
- pop_n = min(out_take, count) when flush is low; otherwise pop_n = 0.
- head advances by pop_n modulo DEPTH.
REQ-021 Occupancy next state: count_next = count - pop_n + push_n; simultaneous push and pop in one cycle SHALL be supported.
REQ-022 Latency: out_* SHALL be driven combinationally from stored entries; an instruction pushed at edge N appears on out_* after edge N.
REQ-023 There SHALL be no write-to-read bypass, so a push into an empty queue is not visible in the same cycle.
REQ-024 Flush priority:
- flush overrides push and take.
- On the next edge head, tail and count go to 0.
- in_ready stays high during a flush cycle, but that cycle's push is dropped.
REQ-025 Pointer wrap: pointers SHALL wrap modulo DEPTH; a bundle that straddles the wrap point is stored and read contiguously in lane order.
REQ-026 Output lanes: for lanes i >= count, out_inst and out_pc SHALL be zero.
REQ-027 err is set on the edge when out_take > count or in_count > LANES (flush low); it holds until reset.
REQ-028 in_ready = (DEPTH - count >= LANES); it is computed from the registered count only, never from same-cycle take.
REQ-029 Fetch SHALL hold its bundle while in_ready is low, and the queue SHALL NOT drop or partially accept a bundle.

Reset
REQ-030 While reset is high, regardless of clock:
- head, tail, count and err SHALL be 0.
- out_valid and out_* SHALL be 0.
- in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared, but they must not be visible.
REQ-032 The first push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 A shared package (cpu_pkg) SHALL hold the IW and AW defaults, the clog2 function, and the instruction/PC lane typedefs.
REQ-034 A single combinational sub-module, fetch_queue_lane_select, SHALL map head+i modulo DEPTH to output lane i; it is instantiated once per direction.
REQ-035 Storage SHALL be a flop array of DEPTH x (IW+AW), with no RAM macro.

Verification (LANES=2, DEPTH=8)
REQ-036 Reset then idle: out_valid=00, count=0, in_ready=1, err=0.
REQ-037 Push sequence:
- Push in_count=2 (PC 0x0000, 0x0002) -> next cycle out_valid=11, out_pc lane0=0x0000, lane1=0x0002, count=2.
- Push 3 further bundles with take=0 -> count=8, in_ready=0.
- A held 5th bundle is not accepted until take=2, and is then accepted on the following edge.
REQ-038 Simultaneous push 2 / take 1 at count=3 -> count=4; out lane0 is the former lane1.
REQ-039 Wrap: with head=6 and count=2, push 2 (tail 0,1) and take 2 -> out lanes show the entries from slots 0 and 1 in order.
REQ-040 Flush: with count=5, flush=1, take=2 and push 2 -> count=0 and out_valid=00 next cycle; the pushed bundle is absent.
REQ-041 Protocol error: take=2 at count=1 -> count=0 and err=1, and err stays 1 until reset is pulsed; a reset asserted between edges clears it asynchronously.
